// File: rtl/logic_gate_prober_pkg.sv
// Shared types and truth-table constants for the logic gate prober.
// Optional feature macro: LOGIC_PROBE_STABLE_CHECK_EN (used by the interface and top).
package logic_probe_pkg;

    typedef enum logic [2:0] {
        GATE_AND     = 3'd0,
        GATE_OR      = 3'd1,
        GATE_NAND    = 3'd2,
        GATE_NOR     = 3'd3,
        GATE_XOR     = 3'd4,
        GATE_XNOR    = 3'd5,
        GATE_NOT_A   = 3'd6,
        GATE_UNKNOWN = 3'd7
    } gate_id_e;

    // Bit i holds y for input vector i = {a,b}
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_XNOR  = 4'b1001;
    localparam logic [3:0] TT_NOT_A = 4'b0011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        CLASSIFY = 2'd2
    } state_e;

endpackage

// File: rtl/logic_gate_prober_if.sv
// Probe/response and result bundle of the logic gate prober.
// With LOGIC_PROBE_STABLE_CHECK_EN defined the bundle also carries 'unstable'.
interface logic_gate_prober_if;

    logic       start;
    logic       probe_a;
    logic       probe_b;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [2:0] gate_id;
`ifdef LOGIC_PROBE_STABLE_CHECK_EN
    logic       unstable;

    modport master (
        output start, dut_y,
        input  probe_a, probe_b, busy, done, truth_table, gate_id, unstable
    );
    modport slave (
        input  start, dut_y,
        output probe_a, probe_b, busy, done, truth_table, gate_id, unstable
    );
`else
    modport master (
        output start, dut_y,
        input  probe_a, probe_b, busy, done, truth_table, gate_id
    );
    modport slave (
        input  start, dut_y,
        output probe_a, probe_b, busy, done, truth_table, gate_id
    );
`endif

endinterface

// File: rtl/logic_gate_prober_classifier.sv
// Combinational classifier: maps a 4-bit truth table to a gate identifier.
module gate_classifier
    import logic_probe_pkg::*;
(
    input  logic [3:0] tt,
    output gate_id_e   gate_id
);

    always_comb begin
        gate_id = GATE_UNKNOWN;
        case (tt)
            TT_AND:   gate_id = GATE_AND;
            TT_OR:    gate_id = GATE_OR;
            TT_NAND:  gate_id = GATE_NAND;
            TT_NOR:   gate_id = GATE_NOR;
            TT_XOR:   gate_id = GATE_XOR;
            TT_XNOR:  gate_id = GATE_XNOR;
            TT_NOT_A: gate_id = GATE_NOT_A;
            default:  gate_id = GATE_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/logic_gate_prober.sv
// Drives a 2-input gate through all four vectors, samples y after a settle time, classifies it.
// Optional LOGIC_PROBE_STABLE_CHECK_EN adds an 'unstable' flag for y changing inside the settle window.
module logic_gate_prober
    import logic_probe_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_gate_prober_if.slave   bus
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0]       shadow;
    gate_id_e         cls_id;
    logic             force_unknown;

    gate_classifier u_classifier (
        .tt      (shadow),
        .gate_id (cls_id)
    );

    assign bus.busy = (state == WAIT) || (state == CLASSIFY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            idx             <= '0;
            shadow          <= '0;
            bus.probe_a     <= 1'b0;
            bus.probe_b     <= 1'b0;
            bus.done        <= 1'b0;
            bus.truth_table <= '0;
            bus.gate_id     <= GATE_UNKNOWN;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx                      <= '0;
                        {bus.probe_a, bus.probe_b} <= 2'b00;
                        cnt                      <= CNT_RELOAD;
                        state                    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // cnt==0 is the sample edge for the vector currently driven
                        shadow[idx] <= bus.dut_y;
                        if (idx == 2'd3) begin
                            state <= CLASSIFY;
                        end else begin
                            idx                        <= idx + 2'd1;
                            {bus.probe_a, bus.probe_b} <= idx + 2'd1;
                            cnt                        <= CNT_RELOAD;
                        end
                    end
                end
                CLASSIFY: begin
                    bus.truth_table <= shadow;
                    bus.gate_id     <= force_unknown ? GATE_UNKNOWN : cls_id;
                    bus.done        <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOGIC_PROBE_STABLE_CHECK_EN
    logic y_early;
    logic run_flag;

    assign force_unknown = run_flag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_early      <= 1'b0;
            run_flag     <= 1'b0;
            bus.unstable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        run_flag <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        y_early <= bus.dut_y;
                    end
                    // With no settle cycles there is no earlier capture to compare against
                    if ((SETTLE_CYCLES > 0) && (cnt == '0) && (y_early != bus.dut_y)) begin
                        run_flag <= 1'b1;
                    end
                end
                CLASSIFY: bus.unstable <= run_flag;
                default: ;
            endcase
        end
    end
`else
    assign force_unknown = 1'b0;
`endif

endmodule

// File: tb/tb_logic_gate_prober.sv
// Self-checking bench for logic_gate_prober: directed scenarios plus random gate models.
// Exercises the 'unstable' flag when LOGIC_PROBE_STABLE_CHECK_EN is defined.
module tb_logic_gate_prober;
    import logic_probe_pkg::*;

    localparam int unsigned P = 2;
    localparam int T = 4 * (P + 1) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_gate_prober_if bus ();

    logic_gate_prober #(.SETTLE_CYCLES(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] cls_tt;
    gate_id_e   cls_out;
    gate_classifier u_cls (
        .tt      (cls_tt),
        .gate_id (cls_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    int         g_sel   = 0;
    logic [3:0] rand_tt = '0;
    logic       inv     = 1'b0;

    // Gate models written as Boolean expressions; g=7 is an arbitrary table
    function automatic logic model_y(input int g, input logic a, input logic b, input logic [3:0] rt);
        case (g)
            0:       return a & b;
            1:       return a | b;
            2:       return ~(a & b);
            3:       return ~(a | b);
            4:       return a ^ b;
            5:       return ~(a ^ b);
            6:       return ~a;
            default: return rt[{a, b}];
        endcase
    endfunction

    function automatic logic [3:0] exp_table(input int g, input logic [3:0] rt);
        logic [3:0] t;
        t = '0;
        for (int v = 0; v < 4; v++) begin
            t[v] = model_y(g, v[1], v[0], rt);
        end
        return t;
    endfunction

    function automatic logic [2:0] exp_id(input logic [3:0] t);
        for (int k = 0; k < 7; k++) begin
            if (exp_table(k, 4'b0000) == t) return 3'(k);
        end
        return 3'd7;
    endfunction

    always_comb bus.dut_y = model_y(g_sel, bus.probe_a, bus.probe_b, rand_tt) ^ inv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_probes", {30'd0, bus.probe_a, bus.probe_b}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_tt", {28'd0, bus.truth_table}, 32'd0);
        check("rst_id", {29'd0, bus.gate_id}, 32'd7);
`ifdef LOGIC_PROBE_STABLE_CHECK_EN
        check("rst_unstable", {31'd0, bus.unstable}, 32'd0);
`endif
    endtask

    // One run; edge 0 is the next rising edge. glitch_edge>0 inverts y over that edge only.
    task automatic run(input int g, input logic [3:0] rt, input bit hold, input bit pulse4,
                       input int glitch_edge);
        logic [3:0] et;
        int         v;
        et      = exp_table(g, rt);
        g_sel   = g;
        rand_tt = rt;
        bus.start = 1'b1;
        for (int e = 0; e <= T; e++) begin
            @(posedge clk);
            #1;
            if (e == 0 && !hold) bus.start = 1'b0;
            if (pulse4 && e == 3) bus.start = 1'b1;
            if (pulse4 && e == 4 && !hold) bus.start = 1'b0;
            if (glitch_edge > 0 && e == glitch_edge - 1) inv = 1'b1;
            if (e == glitch_edge) inv = 1'b0;
            v = e / int'(P + 1);
            if (v > 3) v = 3;
            check($sformatf("probes_e%0d", e), {30'd0, bus.probe_a, bus.probe_b}, 32'(v));
            check($sformatf("busy_e%0d", e), {31'd0, bus.busy}, {31'd0, (e < T)});
            check($sformatf("done_e%0d", e), {31'd0, bus.done}, {31'd0, (e == T)});
        end
        check("truth_table", {28'd0, bus.truth_table}, {28'd0, et});
        check("gate_id", {29'd0, bus.gate_id},
              (glitch_edge > 0 && P > 0) ? 32'd7 : {29'd0, exp_id(et)});
`ifdef LOGIC_PROBE_STABLE_CHECK_EN
        check("unstable", {31'd0, bus.unstable}, {31'd0, (glitch_edge > 0 && P > 0)});
`endif
    endtask

    initial begin
        logic [3:0] last_tt;
        logic [2:0] last_id;
        int         g;
        logic [3:0] rt;

        rst_n     = 1'b0;
        bus.start = 1'b0;

        for (int t = 0; t < 16; t++) begin
            cls_tt = 4'(t);
            #1;
            check($sformatf("classifier_%0h", t), {29'd0, cls_out}, {29'd0, exp_id(4'(t))});
        end

        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        // AND with full timing trace, then results and probes hold
        run(0, 4'b0000, 1'b0, 1'b0, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("hold_probes", {30'd0, bus.probe_a, bus.probe_b}, 32'd3);
            check("hold_done", {31'd0, bus.done}, 32'd0);
            check("hold_tt", {28'd0, bus.truth_table}, 32'h8);
            check("hold_id", {29'd0, bus.gate_id}, 32'd0);
        end

        // Back-to-back: XNOR then NOT_A with start held through the done cycle
        run(5, 4'b0000, 1'b1, 1'b0, 0);
        run(6, 4'b0000, 1'b0, 1'b0, 0);

        // y tied high
        run(7, 4'b1111, 1'b0, 1'b0, 0);

        // Extra start pulse at edge 4 must not restart the run
        run(4, 4'b0000, 1'b0, 1'b1, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("no_second_done", {31'd0, bus.done}, 32'd0);
        end

        // Reset at edge 7 of a run aborts it
        g_sel     = 2;
        bus.start = 1'b1;
        for (int e = 0; e < 7; e++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        for (int e = 0; e < T + 2; e++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", {31'd0, bus.done}, 32'd0);
            check("abort_idle", {31'd0, bus.busy}, 32'd0);
        end
        run(1, 4'b0000, 1'b0, 1'b0, 0);

`ifdef LOGIC_PROBE_STABLE_CHECK_EN
        // XOR with y inverted over the pre-sample capture edge of vector 2
        run(4, 4'b0000, 1'b0, 1'b0, 2 * int'(P + 1) + int'(P));
        run(4, 4'b0000, 1'b0, 1'b0, 0);
`endif

        // Random gate models, including arbitrary tables
        for (int r = 0; r < 8; r++) begin
            g  = int'($urandom_range(0, 7));
            rt = 4'($urandom);
            run(g, rt, 1'b0, 1'b0, 0);
            last_tt = bus.truth_table;
            last_id = bus.gate_id;
            @(posedge clk);
            #1;
            check("rand_hold_tt", {28'd0, bus.truth_table}, {28'd0, exp_table(g, rt)});
            check("rand_hold_id", {29'd0, bus.gate_id}, {29'd0, exp_id(exp_table(g, rt))});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
